// File: rtl/osd_diag_event_packetizer.sv
// rtl/osd_diag_event_packetizer.sv - diagnosis events to DII packet stream with drop reporting
module osd_diag_event_packetizer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [9:0]  id_i,
    input  logic [15:0] event_dest_i,
    input  logic        enable_i,
    input  logic        evt_valid_i,
    input  logic [15:0] evt_id_i,
    input  logic [31:0] evt_time_i,
    input  logic [31:0] evt_data_i,
    output logic [15:0] debug_out_data_o,
    output logic        debug_out_valid_o,
    output logic        debug_out_last_o,
    input  logic        debug_out_ready_i,
    output logic [15:0] drop_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_PKT_LEN);
    localparam logic [CW-1:0] EVT_LAST_IDX = CW'(7);
    localparam logic [CW-1:0] OVF_LAST_IDX = CW'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVT  = 2'd1,
        ST_OVF  = 2'd2
    } state_t;

    // Event buffer: {evt_id, evt_time, evt_data}
    logic [79:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic [79:0]   head;

    state_t        state_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_nxt;
    logic [15:0]   data_q;
    logic          valid_q;
    logic          last_q;
    logic [15:0]   snap_q;

    logic [15:0]   drop_cnt_q;
    logic [15:0]   drop_cnt_d;

    logic          hs;
    logic          pkt_done;
    logic          pop;
    logic          ovf_done;
    logic          evt_req;
    logic          push;
    logic          drop;

    logic [15:0]   evt_next_flit;
    logic [15:0]   ovf_next_flit;

    // The extra pointer bit separates full from empty when the low bits match
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign hs       = valid_q & debug_out_ready_i;
    assign pkt_done = hs & last_q;
    assign pop      = pkt_done && (state_q == ST_EVT);
    assign ovf_done = pkt_done && (state_q == ST_OVF);

    // A pop in the same cycle frees a slot, so a full buffer can still accept
    assign evt_req = evt_valid_i & enable_i;
    assign push    = evt_req & (~fifo_full | pop);
    assign drop    = evt_req & fifo_full & ~pop;

    assign idx_nxt = idx_q + CW'(1);

    // Flit contents of the event packet, selected by the upcoming flit index
    always_comb begin
        evt_next_flit = 16'h0000;
        case (idx_nxt)
            CW'(0):  evt_next_flit = event_dest_i;
            CW'(1):  evt_next_flit = {6'b0, id_i};
            CW'(2):  evt_next_flit = 16'h8000;
            CW'(3):  evt_next_flit = head[79:64];
            CW'(4):  evt_next_flit = head[47:32];
            CW'(5):  evt_next_flit = head[63:48];
            CW'(6):  evt_next_flit = head[15:0];
            default: evt_next_flit = head[31:16];
        endcase
    end

    // Flit contents of the overflow packet; the count comes from the start-of-packet snapshot
    always_comb begin
        ovf_next_flit = 16'h0000;
        case (idx_nxt)
            CW'(0):  ovf_next_flit = event_dest_i;
            CW'(1):  ovf_next_flit = {6'b0, id_i};
            CW'(2):  ovf_next_flit = 16'h8005;
            default: ovf_next_flit = snap_q;
        endcase
    end

    // Pointer next-state: advance on capture and on final event flit accept
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Drop counter: report completion clears it, a coincident drop restarts it at one
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_done) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Event storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {evt_id_i, evt_time_i, evt_data_i};
        end
    end

    // Buffer pointers and drop counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Packet sequencer with registered flit outputs; overflow reports win over events
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            snap_q  <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (drop_cnt_q != 16'd0) begin
                        state_q <= ST_OVF;
                        idx_q   <= '0;
                        data_q  <= event_dest_i;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        snap_q  <= drop_cnt_q;
                    end else if (!fifo_empty) begin
                        state_q <= ST_EVT;
                        idx_q   <= '0;
                        data_q  <= event_dest_i;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                ST_EVT: begin
                    if (hs) begin
                        if (last_q) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                            data_q  <= 16'h0000;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_nxt;
                            data_q  <= evt_next_flit;
                            last_q  <= (idx_nxt == EVT_LAST_IDX);
                        end
                    end
                end
                ST_OVF: begin
                    if (hs) begin
                        if (last_q) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                            data_q  <= 16'h0000;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_nxt;
                            data_q  <= ovf_next_flit;
                            last_q  <= (idx_nxt == OVF_LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    data_q  <= 16'h0000;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign debug_out_data_o  = data_q;
    assign debug_out_valid_o = valid_q;
    assign debug_out_last_o  = last_q;
    assign drop_count_o      = drop_cnt_q;

endmodule

// File: tb/tb_osd_diag_event_packetizer.sv
// tb/tb_osd_diag_event_packetizer.sv - self-checking bench for osd_diag_event_packetizer
module tb_osd_diag_event_packetizer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id;
    logic [15:0] event_dest;
    logic        enable;
    logic        evt_valid;
    logic [15:0] evt_id;
    logic [31:0] evt_time;
    logic [31:0] evt_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    osd_diag_event_packetizer #(.FIFO_DEPTH(DEPTH), .MAX_PKT_LEN(8)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_i              (id),
        .event_dest_i      (event_dest),
        .enable_i          (enable),
        .evt_valid_i       (evt_valid),
        .evt_id_i          (evt_id),
        .evt_time_i        (evt_time),
        .evt_data_i        (evt_data),
        .debug_out_data_o  (out_data),
        .debug_out_valid_o (out_valid),
        .debug_out_last_o  (out_last),
        .debug_out_ready_i (out_ready),
        .drop_count_o      (drop_count)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model state: buffered events, drop count, flits still owed by the current packet
    logic [79:0] mq[$];
    logic [16:0] pkt[$];
    bit          pkt_is_evt;
    logic [15:0] mdrop;
    logic [15:0] seen[$];
    logic        seen_last[$];

    always @(negedge clk) begin
        logic [16:0] f;
        logic [15:0] w[8];
        logic [79:0] e;
        bit          do_clr;
        bit          drop_now;
        if (rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_last", out_last, 0);
            check("rst_data", out_data, 0);
            check("rst_drop", drop_count, 0);
            mq.delete();
            pkt.delete();
            mdrop = 16'd0;
        end else begin
            do_clr = 0;
            check("drop_count", drop_count, mdrop);
            if (pkt.size() == 0) begin
                check("idle_valid", out_valid, 0);
                if (mdrop != 16'd0) begin
                    pkt.push_back({1'b0, event_dest});
                    pkt.push_back({1'b0, 6'b0, id});
                    pkt.push_back({1'b0, 16'h8005});
                    pkt.push_back({1'b1, mdrop});
                    pkt_is_evt = 0;
                end else if (mq.size() != 0) begin
                    e = mq[0];
                    w = '{event_dest, {6'b0, id}, 16'h8000, e[79:64],
                          e[47:32], e[63:48], e[15:0], e[31:16]};
                    for (int i = 0; i < 8; i++) pkt.push_back({(i == 7) ? 1'b1 : 1'b0, w[i]});
                    pkt_is_evt = 1;
                end
            end else begin
                f = pkt[0];
                check("flit_valid", out_valid, 1);
                check("flit_data", out_data, f[15:0]);
                check("flit_last", out_last, f[16]);
                if (out_ready) begin
                    seen.push_back(out_data);
                    seen_last.push_back(out_last);
                    void'(pkt.pop_front());
                    if (f[16]) begin
                        if (pkt_is_evt) void'(mq.pop_front());
                        else do_clr = 1;
                    end
                end
            end
            drop_now = 0;
            if (evt_valid && enable) begin
                if (mq.size() < DEPTH) mq.push_back({evt_id, evt_time, evt_data});
                else drop_now = 1;
            end
            if (do_clr) mdrop = drop_now ? 16'd1 : 16'd0;
            else if (drop_now && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [15:0] i_id, input logic [31:0] i_time, input logic [31:0] i_data);
        evt_valid = 1'b1;
        evt_id    = i_id;
        evt_time  = i_time;
        evt_data  = i_data;
        tick();
        evt_valid = 1'b0;
    endtask

    logic [15:0] exp1[8] = '{16'h0000, 16'h0005, 16'h8000, 16'h0042,
                             16'h5678, 16'h1234, 16'hBEEF, 16'hDEAD};

    initial begin
        bit found;
        rst = 1'b1; id = 10'h5; event_dest = 16'h0000; enable = 1'b1;
        evt_valid = 1'b0; evt_id = '0; evt_time = '0; evt_data = '0; out_ready = 1'b1;
        mdrop = 16'd0; pkt_is_evt = 0;
        ticks(3);
        check("reset_valid_lit", out_valid, 0);
        check("reset_drop_lit", drop_count, 0);
        rst = 1'b0;
        tick();

        // Scenario 1: single event, latency and flit order
        seen.delete(); seen_last.delete();
        send(16'h0042, 32'h12345678, 32'hDEADBEEF);
        check("s1_lat_cycle1", out_valid, 0);
        tick();
        check("s1_lat_cycle2", out_valid, 1);
        check("s1_first_flit", out_data, 16'h0000);
        ticks(12);
        check("s1_count", seen.size(), 8);
        if (seen.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("s1_flit%0d", i), seen[i], exp1[i]);
                check($sformatf("s1_last%0d", i), seen_last[i], (i == 7) ? 1 : 0);
            end
        end

        // Scenario 2: backpressure on flit 3
        seen.delete(); seen_last.delete();
        send(16'h0001, 32'h00020003, 32'h00040005);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (out_valid && out_data == 16'h8000) found = 1;
        end
        check("s2_flit3_seen", found, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s2_hold_data", out_data, 16'h8000);
            check("s2_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        ticks(10);
        check("s2_count", seen.size(), 8);
        if (seen.size() == 8) begin
            check("s2_flit3", seen[2], 16'h8000);
            check("s2_flit4", seen[3], 16'h0001);
            check("s2_flit8", seen[7], 16'h0004);
        end

        // Scenario 3: overflow with depth 4 and seven events
        event_dest = 16'h00AA;
        out_ready = 1'b0;
        seen.delete(); seen_last.delete();
        for (int i = 0; i < 7; i++) send(16'h0100 + 16'(i), {16'(i), 16'h1000}, 32'hC0DE0000 + 32'(i));
        tick();
        check("s3_drop3", drop_count, 16'd3);
        out_ready = 1'b1;
        ticks(60);
        check("s3_count", seen.size(), 36);
        if (seen.size() == 36) begin
            check("s3_evt0_id", seen[3], 16'h0100);
            check("s3_ovf_dest", seen[8], 16'h00AA);
            check("s3_ovf_type", seen[10], 16'h8005);
            check("s3_ovf_cnt", seen[11], 16'h0003);
            check("s3_ovf_last", seen_last[11], 1);
            check("s3_ovf_nolast", seen_last[10], 0);
            check("s3_evt1_id", seen[15], 16'h0101);
            check("s3_evt3_id", seen[31], 16'h0103);
        end
        check("s3_drop_clear", drop_count, 16'd0);

        // Scenario 4: saturation at 16'hFFFF
        out_ready = 1'b0;
        seen.delete(); seen_last.delete();
        for (int i = 0; i < 4; i++) send(16'h0200 + 16'(i), 32'h0, 32'h0);
        tick();
        check("s4_full_nodrop", drop_count, 16'd0);
        force dut.drop_cnt_q = 16'hFFFF;
        mdrop = 16'hFFFF;
        tick();
        release dut.drop_cnt_q;
        tick();
        send(16'h0300, 32'h0, 32'h0);
        tick();
        check("s4_sat1", drop_count, 16'hFFFF);
        send(16'h0301, 32'h0, 32'h0);
        tick();
        check("s4_sat2", drop_count, 16'hFFFF);
        out_ready = 1'b1;
        ticks(60);
        check("s4_count", seen.size(), 36);
        if (seen.size() == 36) check("s4_ovf_cnt", seen[11], 16'hFFFF);
        check("s4_drop_clear", drop_count, 16'd0);

        // Scenario 5: disabled input ignores strobes
        enable = 1'b0;
        seen.delete(); seen_last.delete();
        for (int i = 0; i < 5; i++) send(16'h0400 + 16'(i), 32'h0, 32'h0);
        ticks(10);
        check("s5_no_flits", seen.size(), 0);
        check("s5_no_drop", drop_count, 16'd0);
        enable = 1'b1;

        // Scenario 6: reset mid-packet
        seen.delete(); seen_last.delete();
        send(16'h0500, 32'hAAAA5555, 32'h11112222);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (seen.size() == 4) found = 1;
        end
        check("s6_reached_flit5", found, 1);
        rst = 1'b1;
        #1;
        check("s6_rst_valid", out_valid, 0);
        check("s6_rst_data", out_data, 16'h0000);
        tick();
        rst = 1'b0;
        seen.delete(); seen_last.delete();
        ticks(10);
        check("s6_silent", seen.size(), 0);
        send(16'h0600, 32'h0, 32'h0);
        ticks(12);
        check("s6_count", seen.size(), 8);
        if (seen.size() == 8) begin
            check("s6_first", seen[0], 16'h00AA);
            check("s6_evt_id", seen[3], 16'h0600);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/osd_diag_event_packetizer.md
OSD_DIAG_EVENT_PACKETIZER -- requirements
Module: osd_diag_event_packetizer

Interface
REQ-001 The block SHALL have the following parameter: FIFO_DEPTH, default 4, event buffer depth (power of 2, >=2).
REQ-002 The block SHALL have the following parameter: MAX_PKT_LEN, default 8, maximum flits per packet (must be >=8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port id, input, 10 bits: own DII module address, used as the source flit.
REQ-006 The block SHALL have port event_dest, input, 16 bits: destination address for all packets.
REQ-007 The block SHALL have port enable, input, 1 bit: when 0, incoming events are ignored and not counted.
REQ-008 The block SHALL have port evt_valid, input, 1 bit: one-cycle event strobe from the diagnosis system; there is no backpressure.
REQ-009 The block SHALL have port evt_id, input, 16 bits: event identifier.
REQ-010 The block SHALL have port evt_time, input, 32 bits: event timestamp.
REQ-011 The block SHALL have port evt_data, input, 32 bits: event payload.
REQ-012 The block SHALL have port debug_out, output, dii_flit: the packet stream, with fields data[15:0], valid and last.
REQ-013 The block SHALL have port debug_out_ready, input, 1 bit: downstream accept for debug_out.
REQ-014 The block SHALL have port drop_count, output, 16 bits: current count of dropped events.

Function
REQ-015 An event SHALL be captured when evt_valid=1 and enable=1 and the FIFO is not full, or when the FIFO is full and a pop occurs in the same cycle.
REQ-016 An event SHALL be dropped, and drop_count incremented with saturation at 16'hFFFF, when evt_valid=1 and enable=1 and the FIFO is full with no pop in that cycle.
REQ-017 A flit transfer SHALL occur only when debug_out.valid=1 and debug_out_ready=1.
REQ-018 While debug_out.valid=1 and debug_out_ready=0, debug_out SHALL hold data, valid and last stable.
REQ-019 The event packet SHALL be exactly 8 flits, in this order: event_dest; {6'b0,id}; 16'h8000 (type EVENT, subtype 0); evt_id; evt_time[15:0]; evt_time[31:16]; evt_data[15:0]; evt_data[31:16].
REQ-020 In the event packet, last SHALL be 1 only on flit 8.
REQ-021 The FIFO entry SHALL be popped on the handshake of flit 8.
REQ-022 The overflow packet SHALL be exactly 4 flits, in this order: event_dest; {6'b0,id}; 16'h8005 (type EVENT, subtype 5); drop count snapshot.
REQ-023 In the overflow packet, last SHALL be 1 only on flit 4.
REQ-024 The drop count value carried in flit 4 of the overflow packet SHALL be latched when that packet starts.
REQ-025 On the flit-4 handshake of the overflow packet, drop_count SHALL become 0, or 1 if a drop occurs in the same cycle.
REQ-026 The state machine SHALL have states IDLE, EVT (flit index 0..7) and OVF (flit index 0..3).
REQ-027 From IDLE, the block SHALL enter OVF if drop_count!=0, else enter EVT if the FIFO is non-empty, else remain in IDLE.
REQ-028 OVF SHALL have priority over EVT whenever both conditions hold in IDLE.
REQ-029 After the last-flit handshake, the block SHALL return to IDLE, and debug_out.valid SHALL be 0 for at least that one cycle.
REQ-030 The first flit of a packet SHALL assert debug_out.valid in the cycle after the IDLE decision (latency 2 cycles from evt_valid into an empty, idle block).
REQ-031 A packet, once started, SHALL never be interleaved with another packet or truncated.
REQ-032 Deasserting enable mid-packet SHALL NOT abort the packet in progress.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-034 On rst=1, regardless of clock, the following SHALL take effect: debug_out.valid=0, debug_out.last=0, debug_out.data=0, drop_count=0, FIFO empty, state IDLE.
REQ-035 Reset asserted mid-packet SHALL abandon the packet, and no remaining flits SHALL be emitted after reset release.
REQ-036 The first valid flit after reset release SHALL be flit 1 of a new packet.

Verification
REQ-037 Scenario 1: id=10'h5, event_dest=16'h0, one event (id 16'h0042, time 32'h12345678, data 32'hDEADBEEF), ready=1 -> flits 0000,0005,8000,0042,5678,1234,BEEF,DEAD, with last on the 8th only.
REQ-038 Scenario 2: ready=0 for 10 cycles during flit 3 -> flit 3 data held at 16'h8000 with valid=1 throughout; the stream resumes unchanged.
REQ-039 Scenario 3: FIFO_DEPTH=4, ready=0, 7 strobed events -> 4 buffered, drop_count=3; on ready=1 -> one event packet, then overflow packet ending 16'h0003, then 3 event packets; drop_count=0.
REQ-040 Scenario 4: force drop_count to 16'hFFFF, then one more drop while full -> drop_count remains 16'hFFFF.
REQ-041 Scenario 5: enable=0 with 5 strobes -> no packets and drop_count=0.
REQ-042 Scenario 6: rst pulsed at flit 5 -> valid=0 immediately; after release, the next flit is event_dest of a new packet only if a new event is given.
